multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  7  instr[6:0] from the instruction register; stable from DECODE until FETCH.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 pc_write  output  1  PC register enable.
REQ-007 adr_src  output  1  memory address select; 0 = PC, 1 = ALU result register.
REQ-008 mem_write  output  1  data memory write enable.
REQ-009 ir_write  output  1  instruction register and old-PC register enable.
REQ-010 result_src  output  2  result mux select; 00 = ALUOut, 01 = memory data, 10 = ALU result.
REQ-011 alu_src_a  output  2  ALU A select; 00 = PC, 01 = old PC, 10 = rs1 data.
REQ-012 alu_src_b  output  2  ALU B select; 00 = rs2 data, 01 = immediate, 10 = constant 4.
REQ-013 alu_op  output  2  to the ALU decoder; 00 = add, 01 = subtract/compare, 10 = funct-decoded.
REQ-014 imm_src  output  2  immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 reg_write  output  1  register file write enable.
REQ-016 instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
REQ-017 illegal_op  output  1  one-cycle pulse in DECODE when opcode is unsupported.
REQ-018 state  output  4  current state encoding, for debug.

Function
REQ-019 The block SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
REQ-020 Supported opcodes SHALL be: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-021 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR on lw/sw, EXECUTER on R-type, EXECUTEI on I-ALU, BEQ on beq, JAL on jal, FETCH on any other opcode.
- MEMADR->MEMREAD on lw, MEMWRITE on sw.
- MEMREAD->MEMWB.
- EXECUTER, EXECUTEI and JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
- Encodings 11-15 SHALL go to FETCH on the next edge.
REQ-022 Any output not listed for a state SHALL be 0; no output SHALL ever be X or Z.
REQ-023 Per-state outputs:
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
- MEMREAD: adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
- ALUWB: result_src=00, reg_write=1.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=zero.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
REQ-024 imm_src SHALL be combinational from opcode alone, in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, otherwise 00.
REQ-025 Instruction latency from FETCH entry to return to FETCH SHALL be: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2 cycles.
REQ-026 instr_done SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB and BEQ.
REQ-027 illegal_op SHALL be 1 only in DECODE with an unsupported opcode; instr_done SHALL stay 0 for that instruction.
REQ-028 In BEQ, pc_write SHALL follow zero combinationally in the same cycle.

Reset
REQ-029 Asserting reset SHALL force state to FETCH immediately, without waiting for clk, including mid-instruction.
REQ-030 While reset is high, all outputs SHALL equal FETCH values except pc_write=0 and ir_write=0; instr_done=0 and illegal_op=0.
REQ-031 On the first rising edge after reset deasserts, the block SHALL perform a normal FETCH.

Verification
REQ-032 lw (opcode 0000011) -> state sequence 0,1,2,3,4,0; reg_write=1 and result_src=01 only in state 4; instr_done=1 only in state 4.
REQ-033 sw (0100011) -> sequence 0,1,2,5,0; mem_write=1 only in state 5 with adr_src=1; imm_src=01 throughout.
REQ-034 beq (1100011) with zero=1 -> pc_write=1 in state 9; with zero=0 -> pc_write=0 in state 9; both cases return to state 0 after 3 cycles.
REQ-035 jal (1101111) -> sequence 0,1,10,8,0; pc_write=1 in state 10; reg_write=1 in state 8; imm_src=11.
REQ-036 Opcode 1111111 -> sequence 0,1,0; illegal_op=1 in state 1; no reg_write, mem_write or instr_done pulse.
REQ-037 Reset asserted asynchronously in MEMREAD, mid-cycle -> state=0 before the next edge; pc_write=0 while reset is high; normal FETCH follows on the first edge after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode and
// per-class execute/writeback states, plus combinational immediate-format decode.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0] state_q, state_d;
    logic       op_supported;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        op_supported = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                       (opcode == OP_I) || (opcode == OP_BEQ) || (opcode == OP_JAL);
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                // Enables held off while reset is high so no fetch commits early.
                ir_write   = ~reset;
                pc_write   = ~reset;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                illegal_op = ~op_supported;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
